demux1to2_stream: RTL and testbench
===================================

DEMUX1TO2_STREAM -- requirements
Module: demux1to2_stream

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 8, data bit width.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  source offers a word.
- in_data  input  WIDTH  source word.
- in_sel  input  1  destination: 0 selects channel 0, 1 selects channel 1.
- in_ready  output  1  block accepts the word this cycle.
- out0_valid  output  1  channel 0 holds a word.
- out0_data  output  WIDTH  channel 0 word.
- out0_ready  input  1  channel 0 sink takes the word.
- out1_valid  output  1  channel 1 holds a word.
- out1_data  output  WIDTH  channel 1 word.
- out1_ready  input  1  channel 1 sink takes the word.

Function
REQ-003 Each channel SHALL own a one-entry output register: a valid flag plus a WIDTH-bit data field.
REQ-004 The target channel SHALL be in_sel, or the round-robin pointer when DEMUX_RR_EN is defined.
REQ-005 in_ready SHALL be combinational and equal to (target valid flag is 0) OR (target valid flag is 1 AND target ready is 1).
REQ-006 A transfer SHALL occur when in_valid and in_ready are both 1 on a rising clk edge; in_data is then written to the target register and its valid flag is set.
REQ-007 Latency SHALL be exactly 1 cycle: a word accepted at edge N appears on outX_data with outX_valid=1 immediately after edge N.
REQ-008 A channel drain SHALL occur when outX_valid and outX_ready are both 1 on an edge; the valid flag clears unless a transfer targets the same channel on that edge.
REQ-009 A simultaneous drain and transfer on the same channel SHALL replace the data and keep valid at 1, sustaining 1 word/cycle.
REQ-010 While outX_valid=1 and outX_ready=0, outX_data SHALL hold stable.
REQ-011 The non-target channel SHALL be unaffected by a transfer; it may drain in the same cycle.
REQ-012 While in_valid=0, in_sel and in_data SHALL be don't-care and SHALL NOT alter any state.
REQ-013 Outputs SHALL be driven only from registers, except in_ready (REQ-005).
REQ-014 Words SHALL never be dropped or duplicated, and per-channel order SHALL be preserved.

Reset
REQ-015 When rst=1 at an edge, out0_valid, out1_valid, out0_data, out1_data and the round-robin pointer SHALL all be 0.
REQ-016 in_ready SHALL be 0 while rst=1, and no transfer SHALL occur.
REQ-017 Reset asserted mid-operation SHALL discard held words without emitting them.
REQ-018 The first transfer SHALL be possible on the first edge after rst is deasserted.

Configuration
REQ-019 With macro DEMUX_RR_EN defined:
- in_sel SHALL be ignored.
- A 1-bit pointer, 0 after reset, SHALL select the target channel.
- The pointer SHALL toggle on every transfer and hold otherwise, including while the target channel stalls.
REQ-020 Without DEMUX_RR_EN, the pointer SHALL NOT exist and in_sel alone SHALL select the target channel.

Structure
REQ-021 The channel-index constants CH0=1'b0 and CH1=1'b1 SHALL live in the team's shared Verilog header include file.
REQ-022 The one-entry output register SHALL be a sub-module, demux_out_stage, instantiated twice, with ports clk, rst, load, load_data, valid, data, ready.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, both out valids 0, both out data 0x00.
- Routing: in_sel=1, in_data=0xA5, out1_ready=0 -> next cycle out1_valid=1, out1_data=0xA5, out0_valid=0; a second word to channel 1 sees in_ready=0 and is held until out1_ready=1.
- Stall independence: channel 0 full and stalled, word 0x3C sent to channel 1 -> accepted; out1_data=0x3C; out0_data unchanged.
- Throughput: stream 0x01..0x10 to channel 0 with out0_ready=1 -> 16 words out in order, one per cycle, in_ready constantly 1.
- Reset mid-operation: both channels hold words, then rst=1 for 1 cycle -> both valids 0, neither word observed by any sink.
- DEMUX_RR_EN build: 4 words 0x11, 0x22, 0x33, 0x44 with in_sel=1 -> 0x11 and 0x33 on channel 0, 0x22 and 0x44 on channel 1; a stall on channel 1 holds the pointer until drained.

Source files
------------

// File: rtl/demux1to2_stream_pkg.sv
// Shared types and helpers for the 1-to-2 stream demux.
// Channel indices live in demux1to2_stream_defs.svh.
package demux1to2_stream_pkg;

  typedef logic ch_t;

  // A one-entry slot can take a word if empty or draining now.
  function automatic logic ch_free(
    input logic v,
    input logic r
  );
    return ~v | r;
  endfunction

endpackage

// File: rtl/demux1to2_stream_defs.svh
// Shared channel-index constants for the stream demux.
// Guarded so every file of the slice may include it.
`ifndef DEMUX1TO2_STREAM_DEFS_SVH
`define DEMUX1TO2_STREAM_DEFS_SVH
`define CH0 1'b0
`define CH1 1'b1
`endif

// File: rtl/demux_out_stage.sv
// One-entry output register of the stream demux.
// Load wins over drain so a full slot sustains 1 word/cycle.
module demux_out_stage
  import demux1to2_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  input  logic             ready
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to2_stream.sv
// 1-to-2 valid/ready stream demux with registered outputs.
// Define DEMUX_RR_EN to route round-robin instead of by in_sel.
`include "demux1to2_stream_defs.svh"

module demux1to2_stream
  import demux1to2_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready
);

  ch_t  tgt;
  logic xfer;
  logic load0;
  logic load1;

`ifdef DEMUX_RR_EN
  logic ptr;
  logic unused_sel;

  assign unused_sel = in_sel;
  assign tgt        = ptr;

  // Pointer moves only on accepted words, so a stall pins it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (xfer) begin
      ptr <= ~ptr;
    end
  end
`else
  assign tgt = in_sel;
`endif

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        (tgt == `CH0): in_ready = ch_free(out0_valid, out0_ready);
        (tgt == `CH1): in_ready = ch_free(out1_valid, out1_ready);
        default:       in_ready = 1'b0;
      endcase
    end
  end

  assign xfer  = in_valid & in_ready;
  assign load0 = xfer & (tgt == `CH0);
  assign load1 = xfer & (tgt == `CH1);

  demux_out_stage #(.WIDTH(WIDTH)) u_ch0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (in_data),
    .valid     (out0_valid),
    .data      (out0_data),
    .ready     (out0_ready)
  );

  demux_out_stage #(.WIDTH(WIDTH)) u_ch1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (in_data),
    .valid     (out1_valid),
    .data      (out1_data),
    .ready     (out1_ready)
  );

endmodule

// File: tb/tb_demux1to2_stream.sv
// Bench for demux1to2_stream: directed cases plus random traffic
// against a slot-occupancy model of the two channels.
module tb_demux1to2_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sel = 1'b0;
  logic       in_ready;
  logic       out0_valid;
  logic [7:0] out0_data;
  logic       out0_ready = 1'b0;
  logic       out1_valid;
  logic [7:0] out1_data;
  logic       out1_ready = 1'b0;

  int nvec = 0;
  int nerr = 0;

  // model: each channel is a slot that is empty or holds one word
  bit         mv [2];
  logic [7:0] md [2];
  bit         mptr  = 1'b0;
  bit         armed = 1'b0;

  always #5 clk = ~clk;

  demux1to2_stream #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, compare against the model, then advance it.
  task automatic step(
    input bit       iv,
    input bit [7:0] id,
    input bit       is,
    input bit       r0,
    input bit       r1,
    input bit       rs
  );
    int t;
    bit rdy;
    bit rsel [2];
    @(negedge clk);
    in_valid   = iv;
    in_data    = id;
    in_sel     = is;
    out0_ready = r0;
    out1_ready = r1;
    rst        = rs;
    #1;
`ifdef DEMUX_RR_EN
    t = int'(mptr);
`else
    t = int'(is);
`endif
    rsel[0] = r0;
    rsel[1] = r1;
    rdy = !rs && (!mv[t] || rsel[t]);
    chk("in_ready", in_ready, rdy);
    if (armed) begin
      chk("out0_valid", out0_valid, mv[0]);
      chk("out1_valid", out1_valid, mv[1]);
      if (mv[0]) chk("out0_data", out0_data, md[0]);
      if (mv[1]) chk("out1_data", out1_data, md[1]);
    end
    @(posedge clk);
    if (rs) begin
      mv[0] = 1'b0;
      mv[1] = 1'b0;
      mptr  = 1'b0;
      armed = 1'b1;
    end else begin
      for (int c = 0; c < 2; c++)
        if (mv[c] && rsel[c]) mv[c] = 1'b0;
      if (iv && rdy) begin
        mv[t] = 1'b1;
        md[t] = id;
        mptr  = ~mptr;
      end
    end
  endtask

  initial begin
    // reset with a word offered
    step(1, 8'hFF, 0, 0, 0, 1);
    step(1, 8'hFF, 1, 0, 0, 1);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_d0", out0_data, 8'h00);
    chk("rst_d1", out1_data, 8'h00);

`ifdef DEMUX_RR_EN
    step(1, 8'h11, 1, 1, 1, 0);
    #1;
    chk("rr_d0_11", out0_data, 8'h11);
    chk("rr_v0_11", out0_valid, 1);
    step(1, 8'h22, 1, 1, 1, 0);
    #1;
    chk("rr_d1_22", out1_data, 8'h22);
    step(1, 8'h33, 1, 1, 1, 0);
    #1;
    chk("rr_d0_33", out0_data, 8'h33);
    step(1, 8'h44, 1, 1, 0, 0);
    #1;
    chk("rr_d1_44", out1_data, 8'h44);
    step(1, 8'h55, 1, 1, 0, 0);
    #1;
    chk("rr_d0_55", out0_data, 8'h55);
    step(1, 8'h66, 1, 1, 0, 0);
    #1;
    chk("rr_stall_rdy", in_ready, 0);
    chk("rr_stall_d1", out1_data, 8'h44);
    step(1, 8'h66, 1, 1, 0, 0);
    step(1, 8'h66, 1, 0, 1, 0);
    #1;
    chk("rr_d1_66", out1_data, 8'h66);
    step(1, 8'h77, 1, 1, 1, 0);
    #1;
    chk("rr_d0_77", out0_data, 8'h77);
    chk("rr_v0_77", out0_valid, 1);
`else
    // routing and back-pressure on channel 1
    step(1, 8'hA5, 1, 0, 0, 0);
    #1;
    chk("route_v1", out1_valid, 1);
    chk("route_d1", out1_data, 8'hA5);
    chk("route_v0", out0_valid, 0);
    step(1, 8'h5A, 1, 0, 0, 0);
    #1;
    chk("held_rdy", in_ready, 0);
    chk("held_d1", out1_data, 8'hA5);
    step(1, 8'h5A, 1, 0, 1, 0);
    #1;
    chk("held_d1_new", out1_data, 8'h5A);
    // channel 0 stalled full; channel 1 still accepts
    step(0, 8'h00, 0, 0, 1, 0);
    step(1, 8'h77, 0, 0, 0, 0);
    step(1, 8'h3C, 1, 0, 0, 0);
    #1;
    chk("indep_d1", out1_data, 8'h3C);
    chk("indep_d0", out0_data, 8'h77);
    chk("indep_v0", out0_valid, 1);
    // full-rate stream on channel 0
    step(0, 8'h00, 0, 1, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      step(1, 8'(k), 0, 1, 0, 0);
      #1;
      chk("tp_rdy", in_ready, 1);
      chk("tp_v0", out0_valid, 1);
      chk("tp_d0", out0_data, 8'(k));
    end
    // reset while both channels hold words
    step(0, 8'h00, 0, 1, 1, 0);
    step(1, 8'h66, 0, 0, 0, 0);
    step(1, 8'h99, 1, 0, 0, 0);
    #1;
    chk("mid_v0_pre", out0_valid, 1);
    chk("mid_v1_pre", out1_valid, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    #1;
    chk("mid_v0", out0_valid, 0);
    chk("mid_v1", out1_valid, 0);
    step(0, 8'h00, 0, 1, 1, 0);
    #1;
    chk("mid_v0_after", out0_valid, 0);
    chk("mid_v1_after", out1_valid, 0);
`endif

    for (int n = 0; n < 800; n++) begin
      step(($urandom % 4) != 0,
           8'($urandom),
           1'($urandom),
           ($urandom % 3) != 0,
           1'($urandom),
           ($urandom % 64) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
